data_memory_sized: RTL and testbench
====================================

// Module: data_memory_sized
// PURPOSE
//  Parametrised data memory for the single-cycle MIPS datapath, next generation of the word-only store.
//  Adds byte/halfword/word access with lane write enables and load sign/zero extension.
//  Adds a registered read with a valid/ready request handshake and alignment-fault reporting.
//  Adds a hardware clear sweep after reset. Sits between the ALU address output and the writeback mux.
// PARAMETERS
//  ADDR_WIDTH      7  byte-address width; DEPTH = 2**(ADDR_WIDTH-2) 32-bit words
//  CLEAR_ON_RESET  1  1: zero every word after reset; 0: skip the sweep, contents undefined
// PORTS
//  clock        in   1           rising-edge clock, single domain
//  reset        in   1           synchronous, active-high
//  req_valid    in   1           request present
//  req_ready    out  1           block accepts a request this cycle
//  req_write    in   1           1 = store, 0 = load
//  req_size     in   2           00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1           loads: 1 zero-extend, 0 sign-extend
//  address      in   ADDR_WIDTH  byte address
//  WriteData    in   32          store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid    out  1           one-cycle pulse: load data on MemData
//  MemData      out  32          extended load result, held until next load response
//  misaligned   out  1           one-cycle pulse: accepted request had an alignment fault
//  init_done    out  1           high once the clear sweep is finished
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, MemData=0, misaligned=0, init_done=0; state forced to INIT, clr_ptr=0.
//  FSM INIT:
//   - CLEAR_ON_RESET=1: write 0 to word clr_ptr each cycle, clr_ptr 0..DEPTH-1, then go to IDLE.
//   - CLEAR_ON_RESET=0: spend one cycle in INIT, then go to IDLE.
//   - req_ready=0 throughout INIT.
//  FSM IDLE: req_ready=1 and init_done=1 every cycle; no other states.
//  Reset asserted in any state, including mid-sweep, restarts INIT at clr_ptr=0; no partial sweep survives.
//  Accept = req_valid & req_ready; one request per cycle; back-to-back accepts are allowed.
//  Word index = address[ADDR_WIDTH-1:2], lane = address[1:0]; no out-of-range case exists, index wraps.
//  Alignment fault:
//   - half with address[0]=1; word with address[1:0]!=0; any access with req_size=11.
//  Store, aligned: written at the accept edge.
//   - byte: WriteData[7:0] into lane address[1:0].
//   - half: WriteData[15:0] into lanes {address[1],0}+1 : {address[1],0}.
//   - word: all four lanes.
//   - Other lanes keep their contents.
//  Store produces no rsp_valid.
//  Load latency: exactly 1 cycle; rsp_valid=1 in the cycle after accept.
//   - MemData is the selected byte/half/word, extended per req_unsigned captured at accept.
//  Store then load to the same word on the next cycle returns the new data; there is no stale read.
//  Faulted request: memory is unchanged; misaligned=1 in the cycle after accept.
//   - Faulted load also gives rsp_valid=1 with MemData=0.
//   - Faulted store gives misaligned only.
//  rsp_valid and misaligned are single-cycle pulses; they are never high during INIT.
//  Requests presented while req_ready=0 are ignored (not queued).
//  Little-endian lane order: lane 0 = bits [7:0].
// TESTING  (ADDR_WIDTH=7, DEPTH=32, CLEAR_ON_RESET=1)
//  1. Deassert reset, hold req_valid=1 from the start -> req_ready/init_done rise exactly 32 cycles later.
//     Load word 0x7C -> MemData=0x00000000.
//  2. sw 0x00 0xA5A5A5A5; then:
//     - lb 0x01 -> 0xFFFFFFA5
//     - lbu 0x01 -> 0x000000A5
//     - lh 0x02 -> 0xFFFFA5A5
//     - lw 0x00 -> 0xA5A5A5A5
//     Each rsp_valid comes one cycle after its accept.
//  3. sw 0x20 0x12345678, then sb 0x21 0x000000EE -> lw 0x20 = 0x1234EE78; sh 0x22 0xBEEF -> lw 0x20 = 0xBEEFEE78.
//  4. sw 0x22 0xDEADBEEF -> misaligned pulse, no rsp_valid, lw 0x20 unchanged.
//     lh 0x03 -> rsp_valid=1, misaligned=1, MemData=0.
//  5. Back-to-back with no idle cycle: sw 0x10 0xCAFEF00D then lw 0x10 -> 0xCAFEF00D on the following cycle.
//  6. After test 3, assert reset for 1 cycle at sweep pointer 10 of a later sweep -> ready low 32 more cycles;
//     lw 0x20 -> 0x00000000.

Source files
------------

// File: rtl/data_memory_sized_if.sv
// Request/response bus between the datapath and the sized data memory.
interface data_memory_sized_if #(
  parameter int unsigned ADDR_WIDTH = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           WriteData;
  logic                  rsp_valid;
  logic [31:0]           MemData;
  logic                  misaligned;
  logic                  init_done;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, WriteData,
    input  req_ready, rsp_valid, MemData, misaligned, init_done
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, WriteData,
    output req_ready, rsp_valid, MemData, misaligned, init_done
  );
endinterface

// File: rtl/data_memory_sized.sv
// Byte/half/word data memory with registered load response, alignment-fault
// reporting and an optional zeroing sweep after reset.
module data_memory_sized #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  data_memory_sized_if.slave bus
);
  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0] mem_q [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic             req_ready_q, req_ready_d;
  logic             init_done_q, init_done_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             misaligned_q, misaligned_d;
  logic [31:0]      mem_data_q, mem_data_d;

  logic [IDX_W-1:0] idx_c;
  logic [1:0]       lane_c;
  logic [31:0]      rd_word_c;
  logic [7:0]       rd_byte_c;
  logic [15:0]      rd_half_c;
  logic [31:0]      rd_ext_c;
  logic             accept_c;
  logic             fault_c;
  logic             mem_we_c;
  logic [IDX_W-1:0] mem_idx_c;
  logic [3:0]       mem_be_c;
  logic [31:0]      mem_wdata_c;

  assign idx_c  = bus.address[ADDR_WIDTH-1:2];
  assign lane_c = bus.address[1:0];

  // Select the addressed byte/half/word and apply sign or zero extension
  always_comb begin
    rd_word_c = mem_q[idx_c];
    rd_byte_c = 8'(rd_word_c >> {lane_c, 3'b000});
    rd_half_c = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    rd_ext_c  = rd_word_c;
    case (bus.req_size)
      SZ_BYTE: rd_ext_c = bus.req_unsigned ? {24'h0, rd_byte_c}
                                           : {{24{rd_byte_c[7]}}, rd_byte_c};
      SZ_HALF: rd_ext_c = bus.req_unsigned ? {16'h0, rd_half_c}
                                           : {{16{rd_half_c[15]}}, rd_half_c};
      default: rd_ext_c = rd_word_c;
    endcase
  end

  // Next-state, response and memory-write control
  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    rsp_valid_d  = 1'b0;
    misaligned_d = 1'b0;
    mem_data_d   = mem_data_q;
    mem_we_c     = 1'b0;
    mem_idx_c    = idx_c;
    mem_be_c     = 4'h0;
    mem_wdata_c  = 32'h0;

    accept_c = bus.req_valid & req_ready_q & (state_q == ST_IDLE);
    fault_c  = (bus.req_size == 2'b11) ||
               ((bus.req_size == SZ_HALF) && lane_c[0]) ||
               ((bus.req_size == SZ_WORD) && (lane_c != 2'b00));

    case (state_q)
      ST_INIT: begin
        if (CLEAR_ON_RESET) begin
          mem_we_c    = 1'b1;
          mem_idx_c   = clr_ptr_q;
          mem_be_c    = 4'hF;
          mem_wdata_c = 32'h0;
          if (clr_ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
          else                                clr_ptr_d = clr_ptr_q + IDX_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (accept_c) begin
          misaligned_d = fault_c;
          if (!bus.req_write) begin
            rsp_valid_d = 1'b1;
            mem_data_d  = fault_c ? 32'h0 : rd_ext_c;
          end else if (!fault_c) begin
            mem_we_c = 1'b1;
            case (bus.req_size)
              SZ_BYTE: begin
                mem_be_c    = 4'(4'b0001 << lane_c);
                mem_wdata_c = {4{bus.WriteData[7:0]}};
              end
              SZ_HALF: begin
                mem_be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
                mem_wdata_c = {2{bus.WriteData[15:0]}};
              end
              default: begin
                mem_be_c    = 4'hF;
                mem_wdata_c = bus.WriteData;
              end
            endcase
          end
        end
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    init_done_d = (state_d == ST_IDLE);
  end

  // Control and output registers, synchronous reset restarts the sweep
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_INIT;
      clr_ptr_q    <= '0;
      req_ready_q  <= 1'b0;
      init_done_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      mem_data_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      req_ready_q  <= req_ready_d;
      init_done_q  <= init_done_d;
      rsp_valid_q  <= rsp_valid_d;
      misaligned_q <= misaligned_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // Lane-enabled memory write; suppressed while reset is asserted
  always_ff @(posedge clock) begin
    if (!reset && mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be_c[i]) mem_q[mem_idx_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.init_done  = init_done_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.misaligned = misaligned_q;
  assign bus.MemData    = mem_data_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized (ADDR_WIDTH=7, CLEAR_ON_RESET=1).
module tb_data_memory_sized;
  localparam int unsigned AW = 7;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  data_memory_sized_if #(.ADDR_WIDTH(AW)) bus ();

  data_memory_sized #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request and advance through its accept edge
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [AW-1:0] addr, input logic [31:0] data);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.address      = addr;
    bus.WriteData    = data;
    tick();
  endtask

  task automatic check_rsp(input string tag, input logic rv, input logic mis,
                           input logic [31:0] data);
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
    check({tag, ".misaligned"}, 32'(bus.misaligned), 32'(mis));
    if (rv) check({tag, ".MemData"}, bus.MemData, data);
  endtask

  // Count cycles until ready rises; it must rise on exactly the 32nd
  task automatic check_sweep(input string tag);
    for (int n = 1; n <= 32; n++) begin
      tick();
      check({tag, ".ready"}, 32'(bus.req_ready), 32'(n == 32));
      check({tag, ".init_done"}, 32'(bus.init_done), 32'(n == 32));
      check({tag, ".rsp_quiet"}, 32'(bus.rsp_valid), 32'h0);
      check({tag, ".mis_quiet"}, 32'(bus.misaligned), 32'h0);
    end
  endtask

  initial begin
    clock = 1'b0;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.address      = 7'h7C;
    bus.WriteData    = 32'h0;

    tick();
    tick();
    check("rst.ready", 32'(bus.req_ready), 32'h0);
    check("rst.init_done", 32'(bus.init_done), 32'h0);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst.misaligned", 32'(bus.misaligned), 32'h0);
    check("rst.MemData", bus.MemData, 32'h0);

    // 1: sweep length, then the pending word load at 0x7C
    reset = 1'b0;
    check_sweep("t1");
    tick();
    check_rsp("t1.lw7c", 1'b1, 1'b0, 32'h0000_0000);

    // 2: sized loads of a stored pattern
    issue(1'b1, 2'b10, 1'b0, 7'h00, 32'hA5A5_A5A5);
    check_rsp("t2.sw", 1'b0, 1'b0, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 7'h01, 32'h0);
    check_rsp("t2.lb", 1'b1, 1'b0, 32'hFFFF_FFA5);
    issue(1'b0, 2'b00, 1'b1, 7'h01, 32'h0);
    check_rsp("t2.lbu", 1'b1, 1'b0, 32'h0000_00A5);
    issue(1'b0, 2'b01, 1'b0, 7'h02, 32'h0);
    check_rsp("t2.lh", 1'b1, 1'b0, 32'hFFFF_A5A5);
    issue(1'b0, 2'b10, 1'b0, 7'h00, 32'h0);
    check_rsp("t2.lw", 1'b1, 1'b0, 32'hA5A5_A5A5);

    // 3: partial-lane stores preserve neighbouring lanes
    issue(1'b1, 2'b10, 1'b0, 7'h20, 32'h1234_5678);
    issue(1'b1, 2'b00, 1'b0, 7'h21, 32'h0000_00EE);
    issue(1'b0, 2'b10, 1'b0, 7'h20, 32'h0);
    check_rsp("t3.lw_after_sb", 1'b1, 1'b0, 32'h1234_EE78);
    issue(1'b1, 2'b01, 1'b0, 7'h22, 32'h0000_BEEF);
    issue(1'b0, 2'b10, 1'b0, 7'h20, 32'h0);
    check_rsp("t3.lw_after_sh", 1'b1, 1'b0, 32'hBEEF_EE78);
    issue(1'b0, 2'b01, 1'b1, 7'h22, 32'h0);
    check_rsp("t3.lhu", 1'b1, 1'b0, 32'h0000_BEEF);

    // 4: alignment faults
    issue(1'b1, 2'b10, 1'b0, 7'h22, 32'hDEAD_BEEF);
    check_rsp("t4.sw_mis", 1'b0, 1'b1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 7'h20, 32'h0);
    check_rsp("t4.lw_unchanged", 1'b1, 1'b0, 32'hBEEF_EE78);
    issue(1'b0, 2'b01, 1'b0, 7'h03, 32'h0);
    check_rsp("t4.lh_mis", 1'b1, 1'b1, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 7'h00, 32'h0);
    check_rsp("t4.size11", 1'b1, 1'b1, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 7'h00, 32'h1111_1111);
    check_rsp("t4.st_size11", 1'b0, 1'b1, 32'h0);
    check("t4.MemData_held", bus.MemData, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 7'h00, 32'h0);
    check_rsp("t4.lw0_unchanged", 1'b1, 1'b0, 32'hA5A5_A5A5);

    // 5: back-to-back store then load of the same word
    issue(1'b1, 2'b10, 1'b0, 7'h10, 32'hCAFE_F00D);
    check_rsp("t5.sw", 1'b0, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 7'h10, 32'h0);
    check_rsp("t5.lw", 1'b1, 1'b0, 32'hCAFE_F00D);
    bus.req_valid = 1'b0;
    tick();
    check("t5.rsp_pulse", 32'(bus.rsp_valid), 32'h0);
    check("t5.MemData_hold", bus.MemData, 32'hCAFE_F00D);

    // 6: reset part-way through a sweep restarts it from zero
    reset = 1'b1;
    tick();
    check("t6.rst_ready", 32'(bus.req_ready), 32'h0);
    reset = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    check("t6.midsweep_ready", 32'(bus.req_ready), 32'h0);
    reset = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b10;
    bus.address      = 7'h20;
    tick();
    reset = 1'b0;
    check_sweep("t6");
    tick();
    check_rsp("t6.lw20", 1'b1, 1'b0, 32'h0000_0000);
    issue(1'b0, 2'b10, 1'b0, 7'h00, 32'h0);
    check_rsp("t6.lw00", 1'b1, 1'b0, 32'h0000_0000);
    bus.req_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
